// File: rtl/sample_uart_tx.sv
// UART 8N1 transmitter fed by a small FIFO of captured samples (rising-edge valid).
// Optional even parity bit between data and stop when SAMPLE_UART_PARITY_EN is defined.
module sample_uart_tx #(
    parameter int BAUD_DIV = 43,
    parameter int FIFO_AW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               overflow
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SAMPLE_UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int DEPTH_I = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH     = (FIFO_AW+1)'(DEPTH_I);
    localparam logic [7:0]       BAUD_LAST = 8'(BAUD_DIV - 1);

    logic [7:0]       mem [DEPTH_I];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       state_q, state_d;
    logic [7:0]       baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             tx_q, tx_d;
    logic             valid_d1_q;
    logic             overflow_q, overflow_d;
    logic             wr_req, full, push, pop, baud_last;
    logic [7:0]       head;
`ifdef SAMPLE_UART_PARITY_EN
    logic             par_q, par_d;
`endif

    assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
    assign full      = (fifo_cnt == DEPTH);
    assign wr_req    = din_valid & ~valid_d1_q;
    // Fullness is judged before any same-cycle pop, so a full FIFO drops the write.
    assign push      = wr_req & ~full;
    assign baud_last = (baud_q == BAUD_LAST);
    assign head      = mem[rd_ptr_q[FIFO_AW-1:0]];

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (wr_req & full);
`ifdef SAMPLE_UART_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fifo_cnt != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = 8'd0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    baud_d  = 8'd0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = 8'd0;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef SAMPLE_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
`ifdef SAMPLE_UART_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    baud_d  = 8'd0;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_d = 8'd0;
                    // Chain straight into the next start bit when more data is queued.
                    if (fifo_cnt != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = 8'd0;
            end
        endcase

        if (pop) begin
            sh_d = head;
`ifdef SAMPLE_UART_PARITY_EN
            par_d = ^head;
`endif
        end

        wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};

        // tx is registered, so it is driven from the state being entered.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_d[0];
`ifdef SAMPLE_UART_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= S_IDLE;
            baud_q     <= 8'd0;
            bit_q      <= 3'd0;
            tx_q       <= 1'b1;
            valid_d1_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            valid_d1_q <= din_valid;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q <= sh_d;
`ifdef SAMPLE_UART_PARITY_EN
        par_q <= par_d;
`endif
        if (push && !rst) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= din;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;

endmodule

// File: doc/sample_uart_tx.md
Name: sample_uart_tx

Overview:
- Downstream consumer of the SPI sample-capture stage. Takes each captured 8-bit sample (data bus plus `done`-style valid level) and queues it in a small FIFO.
- Serialises queued samples onto a UART TX line, 8N1, LSB first, so ADC samples stream to a host terminal.
- Sits between the SPI master's `led`/`done` outputs and the board TX pin.

Parameters:
- BAUD_DIV, 43, clocks per UART bit (5 MHz / 43 ≈ 115200 baud); legal range 2..255.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset; one clock (clk), and rst is sampled only on the rising edge of clk
- din  input  8  sample byte; valid whenever din_valid is high
- din_valid  input  1  sample-ready level; may stay high for many cycles; only its rising edge is consumed
- tx  output  1  UART serial output, idle high
- busy  output  1  high while a frame is on the line (state != IDLE)
- fifo_cnt  output  FIFO_AW+1  number of queued bytes not yet popped
- overflow  output  1  sticky; set when a sample is dropped because the FIFO is full

Behaviour:
- Reset (rst=1 at a clk edge): tx=1, busy=0, fifo_cnt=0, overflow=0, state=IDLE, baud counter=0, valid_d1=0. FIFO pointers are cleared, so contents are discarded.
- Reset mid-frame: tx returns high on the next edge; the partial frame is abandoned with no completion.
- Edge detect: valid_d1 registers din_valid. A write request is din_valid & ~valid_d1. The din value is captured on that same cycle.
- Write when fifo_cnt < depth: push din; fifo_cnt increments, unless a pop occurs in the same cycle, in which case it is unchanged.
- Write when fifo_cnt == depth: the byte is dropped and overflow is set. Fullness is evaluated before any same-cycle pop, so a write is dropped even if a pop happens in that cycle.
- FIFO pointers are FIFO_AW+1 bits wide and wrap naturally. fifo_cnt = wr_ptr - rd_ptr.
- FSM states:
  - IDLE: tx=1.
    - If fifo_cnt != 0: pop the head into shift register sh[7:0], baud counter=0, go to START.
  - START: tx=0 for BAUD_DIV clocks, then go to DATA with bit index 0.
  - DATA: tx=sh[0] for BAUD_DIV clocks per bit; shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV clocks.
    - On the last STOP cycle, if fifo_cnt != 0: pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- tx is a registered output. The start bit appears on tx on the clock after the pop cycle.
- The frame is exactly 10*BAUD_DIV clocks (11*BAUD_DIV with parity).
- Baud counter: 8 bits, counts 0..BAUD_DIV-1 within each bit, resets to 0 at every bit boundary.
- busy=1 from the cycle tx first drops low until the cycle after the final STOP clock. When frames run back-to-back, busy stays high across them.
- Simultaneous push and pop with a non-full FIFO: both take effect and fifo_cnt is unchanged.

Optional Feature:
- Macro: SAMPLE_UART_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted as state PARITY between DATA and STOP. It lasts BAUD_DIV clocks, making the frame 11*BAUD_DIV clocks.
- Undefined: no PARITY state; frame is 8N1, 10*BAUD_DIV clocks.

Test Plan (BAUD_DIV=4, FIFO_AW=2):
1. Reset: assert rst 3 cycles -> tx=1, busy=0, fifo_cnt=0, overflow=0. Then apply din_valid pulse during rst -> nothing queued after release.
2. Single byte: din=0xA5, din_valid high 1 cycle.
   - tx sequence (4 clocks each) is 0,1,0,1,0,0,1,0,1,1; total 40 clocks.
   - busy falls after the stop bit; fifo_cnt returns to 0.
3. Level valid: din=0x3C, din_valid held high 50 cycles -> exactly one frame (0,0,0,1,1,1,1,0,0,1), not repeated.
4. Overflow: 6 rising edges 2 cycles apart, bytes 0x01..0x06.
   - 0x01..0x05 transmitted back-to-back with no idle-high gap between stop and start.
   - 0x06 is dropped; overflow=1 and stays set until rst.
5. Reset mid-frame: rst at clock 15 of a 0xFF frame -> tx=1 next edge, busy=0, fifo_cnt=0. A new byte 0x55 afterwards transmits correctly.
6. With SAMPLE_UART_PARITY_EN: din=0x07 -> parity bit 1, frame 44 clocks. din=0x03 -> parity bit 0.
